// File: rtl/craft_round_constants_gen_pkg.sv
// Shared CRAFT round-constant definitions: LFSR seeds, FSM encodings and a
// constant-evaluable helper that returns the (a4,a3) LFSR pair for any round.
package craft_defs;

    localparam logic [3:0] RC4_INIT = 4'h1;
    localparam logic [2:0] RC3_INIT = 3'h1;
    localparam int         RC_W     = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Forward-steps the seeds r times; the 4-bit and 3-bit LFSRs have
    // periods 15 and 7, so only r mod 15 / r mod 7 steps are applied.
    function automatic logic [6:0] craft_rc_at_round(input int r);
        logic [3:0] a4;
        logic [2:0] a3;
        a4 = RC4_INIT;
        a3 = RC3_INIT;
        for (int i = 0; i < 15; i++) begin
            if (i < (r % 15)) a4 = {a4[1] ^ a4[0], a4[3:1]};
        end
        for (int i = 0; i < 7; i++) begin
            if (i < (r % 7)) a3 = {a3[1] ^ a3[0], a3[2:1]};
        end
        return {a4, a3};
    endfunction

endpackage

// File: rtl/craft_round_constants_gen_lfsr_step.sv
// One combinational step of the paired CRAFT round-constant LFSRs,
// forward (dir=0, encrypt order) or reverse (dir=1, decrypt order).
module craft_rc_lfsr_step (
    input  logic       dir,
    input  logic [3:0] a4,
    input  logic [2:0] a3,
    output logic [3:0] n4,
    output logic [2:0] n3
);

    always_comb begin
        if (!dir) begin
            n4 = {a4[1] ^ a4[0], a4[3:1]};
            n3 = {a3[1] ^ a3[0], a3[2:1]};
        end else begin
            n4 = {a4[2:0], a4[3] ^ a4[0]};
            n3 = {a3[1:0], a3[2] ^ a3[0]};
        end
    end

endmodule

// File: rtl/craft_round_constants_gen.sv
// CRAFT round-constant generator: UNROLL constants per enabled cycle in
// encrypt or decrypt order, with start/busy/last/done sequencing.
module craft_round_constants_gen
    import craft_defs::*;
#(
    parameter int  UNROLL     = 1,
    parameter int  NUM_ROUNDS = 32,
    localparam int RIDX_W     = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     start,
    input  logic                     dec,
    output logic [RC_W*UNROLL-1:0]   rc,
    output logic [RIDX_W-1:0]        round_idx,
    output logic                     busy,
    output logic                     last,
    output logic                     done
);

    if ((NUM_ROUNDS % UNROLL) != 0 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_cfg
        $error("craft_round_constants_gen: UNROLL must be 1/2/4 and divide NUM_ROUNDS");
    end

    localparam logic [6:0]        DEC_INIT = craft_rc_at_round(NUM_ROUNDS - 1);
    localparam logic [6:0]        ENC_INIT = {RC4_INIT, RC3_INIT};
    localparam logic [RIDX_W-1:0] STEP     = RIDX_W'(UNROLL);
    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - UNROLL);

    logic [1:0]        st_p0;
    logic [3:0]        a4_p0;
    logic [2:0]        a3_p0;
    logic              dir_p0;
    logic [RIDX_W-1:0] ridx_p0;

    // Step chain: entry k is lane-0 state advanced k times; the last entry
    // is the next lane-0 state once the whole group retires.
    logic [3:0] c4 [UNROLL+1];
    logic [2:0] c3 [UNROLL+1];

    assign c4[0] = a4_p0;
    assign c3[0] = a3_p0;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        craft_rc_lfsr_step u_step (
            .dir (dir_p0),
            .a4  (c4[k]),
            .a3  (c3[k]),
            .n4  (c4[k+1]),
            .n3  (c3[k+1])
        );
    end

    assign busy      = (st_p0 == ST_RUN);
    assign last      = busy && (ridx_p0 == LAST_IDX);
    assign done      = (st_p0 == ST_DONE);
    assign round_idx = ridx_p0;

    always_comb begin
        rc = '0;
        if (busy) begin
            for (int k = 0; k < UNROLL; k++) begin
                rc[RC_W*k +: RC_W] = {c4[k], 1'b0, c3[k]};
            end
        end
    end

    // ---- state register: the only clocked stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_p0   <= ST_IDLE;
            a4_p0   <= 4'h0;
            a3_p0   <= 3'h0;
            dir_p0  <= 1'b0;
            ridx_p0 <= '0;
        end else if (ce) begin
            case (st_p0)
                ST_IDLE: begin
                    if (start) begin
                        st_p0            <= ST_RUN;
                        dir_p0           <= dec;
                        {a4_p0, a3_p0}   <= dec ? DEC_INIT : ENC_INIT;
                        ridx_p0          <= '0;
                    end
                end
                ST_RUN: begin
                    a4_p0 <= c4[UNROLL];
                    a3_p0 <= c3[UNROLL];
                    if (last) begin
                        st_p0   <= ST_DONE;
                        ridx_p0 <= '0;
                    end else begin
                        ridx_p0 <= ridx_p0 + STEP;
                    end
                end
                ST_DONE: st_p0 <= ST_IDLE;
                default: st_p0 <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_craft_round_constants_gen.sv
// Bench for craft_round_constants_gen: three instances (UNROLL 1/2/4) driven
// from a vector table plus hand-written reset/ce corner sequences.
module tb_craft_round_constants_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  ce_v, start_v, dec_v;
    logic [2:0]  busy_v, last_v, done_v;
    logic [7:0]  rc1;
    logic [15:0] rc2;
    logic [31:0] rc4;
    logic [5:0]  ridx1, ridx2, ridx4;

    craft_round_constants_gen #(.UNROLL(1), .NUM_ROUNDS(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce_v[0]), .start(start_v[0]), .dec(dec_v[0]),
        .rc(rc1), .round_idx(ridx1), .busy(busy_v[0]), .last(last_v[0]), .done(done_v[0]));

    craft_round_constants_gen #(.UNROLL(2), .NUM_ROUNDS(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce_v[1]), .start(start_v[1]), .dec(dec_v[1]),
        .rc(rc2), .round_idx(ridx2), .busy(busy_v[1]), .last(last_v[1]), .done(done_v[1]));

    craft_round_constants_gen #(.UNROLL(4), .NUM_ROUNDS(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce_v[2]), .start(start_v[2]), .dec(dec_v[2]),
        .rc(rc4), .round_idx(ridx4), .busy(busy_v[2]), .last(last_v[2]), .done(done_v[2]));

    int checks = 0;
    int errors = 0;

    // CRAFT round constants for rounds 0..31, encrypt order.
    logic [7:0] rc_tab [32];

    typedef struct {
        int          sel;
        bit          dec;
        bit          rand_ce;
        bit          disturb;
        logic [31:0] first_rc;
        logic [31:0] last_rc;
    } vec_t;

    vec_t vecs [7];

    always @(negedge clk) begin
        if (rst_n && busy_v[0]) begin
            assert (rc1[7:4] != 4'h0 && rc1[2:0] != 3'h0)
                else $error("lfsr reached all-zero state while running");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_rc(input int s);
        case (s)
            0:       return {24'd0, rc1};
            1:       return {16'd0, rc2};
            default: return rc4;
        endcase
    endfunction

    function automatic logic [31:0] get_ridx(input int s);
        case (s)
            0:       return {26'd0, ridx1};
            1:       return {26'd0, ridx2};
            default: return {26'd0, ridx4};
        endcase
    endfunction

    function automatic logic [31:0] bit32(input logic b);
        return {31'd0, b};
    endfunction

    function automatic logic [31:0] exp_group(input int u, input bit d, input int g);
        logic [31:0] e;
        int r;
        e = '0;
        for (int k = 0; k < u; k++) begin
            r = g * u + k;
            if (d) r = 31 - r;
            e[8*k +: 8] = rc_tab[r];
        end
        return e;
    endfunction

    task automatic run_seq(input int s, input bit d, input bit rand_ce, input bit disturb,
                           output logic [31:0] first_rc, output logic [31:0] last_rc);
        int u, ng, g, cyc;
        bit cen;
        u = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        ng = 32 / u;
        first_rc = '0;
        last_rc  = '0;
        ce_v[s]    = 1'b1;
        start_v[s] = 1'b1;
        dec_v[s]   = d;
        @(negedge clk);
        start_v[s] = 1'b0;
        g = 0;
        cyc = 0;
        while (g < ng && cyc < 200) begin
            chk("busy", bit32(busy_v[s]), 32'd1);
            chk("rc", get_rc(s), exp_group(u, d, g));
            chk("round_idx", get_ridx(s), 32'(g * u));
            chk("last", bit32(last_v[s]), bit32(g == ng - 1));
            chk("done_in_run", bit32(done_v[s]), 32'd0);
            if (g == 0) first_rc = get_rc(s);
            if (g == ng - 1) last_rc = get_rc(s);
            cen = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            ce_v[s]    = cen;
            start_v[s] = disturb && (g == 3);
            dec_v[s]   = (disturb && g >= 2) ? ~d : d;
            @(negedge clk);
            cyc++;
            if (cen) g++;
        end
        start_v[s] = 1'b0;
        chk("group_budget", 32'(g), 32'(ng));
        chk("done_pulse", bit32(done_v[s]), 32'd1);
        chk("busy_after", bit32(busy_v[s]), 32'd0);
        chk("last_after", bit32(last_v[s]), 32'd0);
        chk("rc_after", get_rc(s), 32'd0);
        ce_v[s]    = 1'b1;
        start_v[s] = disturb;
        @(negedge clk);
        start_v[s] = 1'b0;
        dec_v[s]   = 1'b0;
        chk("done_one_cycle", bit32(done_v[s]), 32'd0);
        chk("idle_busy", bit32(busy_v[s]), 32'd0);
        chk("idle_rc", get_rc(s), 32'd0);
    endtask

    initial begin
        logic [31:0] f, l;
        rst_n   = 1'b0;
        ce_v    = '0;
        start_v = '0;
        dec_v   = '0;
        rc_tab = '{8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h63, 8'hB1,
                   8'h54, 8'hA2, 8'hD5, 8'hE6, 8'hF7, 8'h73, 8'h31, 8'h14,
                   8'h82, 8'h45, 8'h26, 8'h97, 8'hC3, 8'h61, 8'hB4, 8'h52,
                   8'hA5, 8'hD6, 8'hE7, 8'hF3, 8'h71, 8'h34, 8'h12, 8'h85};
        vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 32'h0000_0011, 32'h0000_0085};
        vecs[1] = '{0, 1'b1, 1'b0, 1'b0, 32'h0000_0085, 32'h0000_0011};
        vecs[2] = '{1, 1'b0, 1'b0, 1'b0, 32'h0000_8411, 32'h0000_8512};
        vecs[3] = '{2, 1'b1, 1'b1, 1'b0, 32'h7134_1285, 32'h1184_4225};
        vecs[4] = '{2, 1'b0, 1'b0, 1'b0, 32'h2542_8411, 32'h8512_3471};
        vecs[5] = '{0, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 32'h0000_0085};
        vecs[6] = '{1, 1'b1, 1'b0, 1'b1, 32'h0000_1285, 32'h0000_1184};

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset_rc", get_rc(s), 32'd0);
            chk("reset_ridx", get_ridx(s), 32'd0);
            chk("reset_busy", bit32(busy_v[s]), 32'd0);
            chk("reset_last", bit32(last_v[s]), 32'd0);
            chk("reset_done", bit32(done_v[s]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // start while ce=0 must be ignored
        ce_v[0]    = 1'b0;
        start_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_no_ce_busy", bit32(busy_v[0]), 32'd0);
        chk("start_no_ce_rc", get_rc(0), 32'd0);
        start_v[0] = 1'b0;
        ce_v[0]    = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_seq(vecs[i].sel, vecs[i].dec, vecs[i].rand_ce, vecs[i].disturb, f, l);
            chk("first_group", f, vecs[i].first_rc);
            chk("final_group", l, vecs[i].last_rc);
        end

        // asynchronous reset in the middle of a run
        ce_v[0]    = 1'b1;
        dec_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_rc", get_rc(0), 32'h0000_00C7);
        chk("pre_reset_ridx", get_ridx(0), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rc", get_rc(0), 32'd0);
        chk("async_rst_busy", bit32(busy_v[0]), 32'd0);
        chk("async_rst_ridx", get_ridx(0), 32'd0);
        chk("async_rst_done", bit32(done_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", bit32(done_v[0]), 32'd0);
            chk("idle_after_rst", bit32(busy_v[0]), 32'd0);
        end
        run_seq(0, 1'b0, 1'b0, 1'b0, f, l);
        chk("restart_first", f, 32'h0000_0011);
        chk("restart_final", l, 32'h0000_0085);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
